// File: rtl/am74ls259s.sv
// ============================================================================
// Module     : am74ls259s
// Description: Clocked 8-bit addressable latch / 1-of-8 demux with a serial
//              LSB-first deserializer. Optional tri-state outputs on q/pq are
//              enabled by defining AM74LS259S_TRISTATE_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module am74ls259s (
  input  logic       clk,
  input  logic       clr_,
  input  logic       d,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       g_,
  input  logic [1:0] md,
`ifdef AM74LS259S_TRISTATE_EN
  input  logic       oe_,
`endif
  output logic [7:0] q,
  output logic [7:0] pq,
  output logic       rdy,
  output logic [2:0] cnt
);

  localparam logic [1:0] c_MD_HOLD  = 2'b00;
  localparam logic [1:0] c_MD_LATCH = 2'b01;
  localparam logic [1:0] c_MD_DEMUX = 2'b10;
  localparam logic [1:0] c_MD_SER   = 2'b11;

  logic [7:0] r_q;
  logic [7:0] r_pq;
  logic       r_rdy;
  logic [2:0] r_cnt;

  logic [2:0] w_addr;
  logic [7:0] w_demux;

  assign w_addr = {c, b, a};

  always_comb begin
    w_demux         = 8'h00;
    w_demux[w_addr] = d;
  end

  // Every enabled non-serial cycle resynchronises the bit counter; g_=1
  // freezes everything so a serial bubble keeps its position.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      r_q   <= 8'h00;
      r_pq  <= 8'h00;
      r_rdy <= 1'b0;
      r_cnt <= 3'd0;
    end else begin
      r_rdy <= 1'b0;
      if (!g_) begin
        case (md)
          c_MD_HOLD: begin
            r_cnt <= 3'd0;
          end
          c_MD_LATCH: begin
            r_q[w_addr] <= d;
            r_cnt       <= 3'd0;
          end
          c_MD_DEMUX: begin
            r_q   <= w_demux;
            r_cnt <= 3'd0;
          end
          c_MD_SER: begin
            r_q[r_cnt] <= d;
            r_cnt      <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_pq  <= {d, r_q[6:0]};
              r_rdy <= 1'b1;
            end
          end
          default: begin
            r_cnt <= 3'd0;
          end
        endcase
      end
    end
  end

`ifdef AM74LS259S_TRISTATE_EN
  assign q  = oe_ ? 8'bz : r_q;
  assign pq = oe_ ? 8'bz : r_pq;
`else
  assign q  = r_q;
  assign pq = r_pq;
`endif
  assign rdy = r_rdy;
  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_am74ls259s.sv
// ============================================================================
// Module     : tb_am74ls259s
// Description: Scoreboard bench for am74ls259s using directed vectors.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_am74ls259s;

  logic       clk;
  logic       clr_;
  logic       d, a, b, c, g_;
  logic [1:0] md;
  logic [7:0] q, pq;
  logic       rdy;
  logic [2:0] cnt;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [7:0] pq;
    logic       rdy;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 0;

  am74ls259s dut (
    .clk  (clk),
    .clr_ (clr_),
    .d    (d),
    .a    (a),
    .b    (b),
    .c    (c),
    .g_   (g_),
    .md   (md),
`ifdef AM74LS259S_TRISTATE_EN
    .oe_  (1'b0),
`endif
    .q    (q),
    .pq   (pq),
    .rdy  (rdy),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string nm, input logic [7:0] eq, input logic [7:0] epq,
                          input logic er, input logic [2:0] ec);
    exp_t e;
    e.name = nm;
    e.q    = eq;
    e.pq   = epq;
    e.rdy  = er;
    e.cnt  = ec;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, let the edge happen, then queue its expected result.
  task automatic step(input string nm, input logic g, input logic [1:0] m,
                      input logic [2:0] ad, input logic dd,
                      input logic [7:0] eq, input logic [7:0] epq,
                      input logic er, input logic [2:0] ec);
    g_ = g;
    md = m;
    {c, b, a} = ad;
    d = dd;
    @(posedge clk);
    #1;
    push_exp(nm, eq, epq, er, ec);
  endtask

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (q === e.q && pq === e.pq && rdy === e.rdy && cnt === e.cnt) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got q=%h pq=%h rdy=%b cnt=%0d, expected q=%h pq=%h rdy=%b cnt=%0d",
                   e.name, q, pq, rdy, cnt, e.q, e.pq, e.rdy, e.cnt);
        end
      end
    end
  end

  logic [7:0] fill_exp [8];
  logic [7:0] ser1_q   [8];
  logic [2:0] ser1_c   [8];
  logic [7:0] ser2_q   [8];
  logic [7:0] ser3_q   [8];

  initial begin
    fill_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    // Byte 4D from q=83: 1,0,1,1,0,0,1,0
    ser1_q   = '{8'h83, 8'h81, 8'h85, 8'h8D, 8'h8D, 8'h8D, 8'hCD, 8'h4D};
    ser1_c   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    // All ones from q=4D
    ser2_q   = '{8'h4D, 8'h4F, 8'h4F, 8'h4F, 8'h5F, 8'h7F, 8'h7F, 8'hFF};
    // Byte A5 from q=FA: 1,0,1,0,0,1,0,1
    ser3_q   = '{8'hFB, 8'hF9, 8'hFD, 8'hF5, 8'hE5, 8'hE5, 8'hA5, 8'hA5};

    clr_ = 1'b0; g_ = 1'b1; md = 2'b00; d = 1'b0; {c, b, a} = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_state", 8'h00, 8'h00, 1'b0, 3'd0);
    clr_ = 1'b1;

    // Fill q with ones, then walk the counter to 5
    for (int i = 0; i < 8; i++)
      step("fill", 1'b0, 2'b01, 3'(i), 1'b1, fill_exp[i], 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++)
      step("ser_pre", 1'b0, 2'b11, 3'd0, 1'b1, 8'hFF, 8'h00, 1'b0, 3'(i + 1));

    // Asynchronous reset in the middle of a cycle
    @(negedge clk);
    #1;
    clr_ = 1'b0;
    #1;
    push_exp("async_reset", 8'h00, 8'h00, 1'b0, 3'd0);
    -> sample_ev;
    g_ = 1'b0; md = 2'b01; d = 1'b1;
    @(posedge clk);
    #1;
    push_exp("reset_held", 8'h00, 8'h00, 1'b0, 3'd0);
    clr_ = 1'b1;

    step("latch_a3",  1'b0, 2'b01, 3'd3, 1'b1, 8'h08, 8'h00, 1'b0, 3'd0);
    step("latch_a6",  1'b0, 2'b01, 3'd6, 1'b1, 8'h48, 8'h00, 1'b0, 3'd0);
    step("latch_a3z", 1'b0, 2'b01, 3'd3, 1'b0, 8'h40, 8'h00, 1'b0, 3'd0);
    step("demux_a5",  1'b0, 2'b10, 3'd5, 1'b1, 8'h20, 8'h00, 1'b0, 3'd0);
    step("demux_a5z", 1'b0, 2'b10, 3'd5, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
    step("latch_a7",  1'b0, 2'b01, 3'd7, 1'b1, 8'h80, 8'h00, 1'b0, 3'd0);
    step("hold_g",    1'b1, 2'b01, 3'd2, 1'b1, 8'h80, 8'h00, 1'b0, 3'd0);

    step("ser_s0", 1'b0, 2'b11, 3'd7, 1'b1, 8'h81, 8'h00, 1'b0, 3'd1);
    step("ser_s1", 1'b0, 2'b11, 3'd7, 1'b1, 8'h83, 8'h00, 1'b0, 3'd2);
    step("ser_s2", 1'b0, 2'b11, 3'd7, 1'b0, 8'h83, 8'h00, 1'b0, 3'd3);
    step("ser_s3", 1'b0, 2'b11, 3'd7, 1'b0, 8'h83, 8'h00, 1'b0, 3'd4);
    step("hold_md0", 1'b0, 2'b00, 3'd5, 1'b1, 8'h83, 8'h00, 1'b0, 3'd0);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] bits;
      bits = 8'h4D;
      step("deser_4d", 1'b0, 2'b11, 3'd0, bits[i], ser1_q[i],
           (i == 7) ? 8'h4D : 8'h00, (i == 7), ser1_c[i]);
    end
    for (int i = 0; i < 8; i++)
      step("deser_ff", 1'b0, 2'b11, 3'd0, 1'b1, ser2_q[i],
           (i == 7) ? 8'hFF : 8'h4D, (i == 7), ser1_c[i]);

    step("pause_b0", 1'b0, 2'b11, 3'd0, 1'b0, 8'hFE, 8'hFF, 1'b0, 3'd1);
    step("pause_b1", 1'b0, 2'b11, 3'd0, 1'b1, 8'hFE, 8'hFF, 1'b0, 3'd2);
    step("pause_b2", 1'b0, 2'b11, 3'd0, 1'b0, 8'hFA, 8'hFF, 1'b0, 3'd3);
    for (int i = 0; i < 4; i++)
      step("pause_hold", 1'b1, 2'b11, 3'd0, 1'b1, 8'hFA, 8'hFF, 1'b0, 3'd3);
    step("resync", 1'b0, 2'b01, 3'd0, 1'b0, 8'hFA, 8'hFF, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] bits;
      bits = 8'hA5;
      step("deser_a5", 1'b0, 2'b11, 3'd4, bits[i], ser3_q[i],
           (i == 7) ? 8'hA5 : 8'hFF, (i == 7), ser1_c[i]);
    end
    step("rdy_drop", 1'b1, 2'b11, 3'd0, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd0);

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
